// File: rtl/axi_rd_arbiter.sv
// N-port AXI3 read arbiter: one outstanding burst, flush/drain support.
// Define AXI_RD_ARB_RR_EN for round-robin grants; default is fixed priority.
module axi_rd_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        flush,
    input  logic [NUM_PORTS-1:0]        req_valid,
    output logic [NUM_PORTS-1:0]        req_ready,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*4-1:0]      req_len,
    input  logic [NUM_PORTS*3-1:0]      req_size,
    output logic [DATA_W-1:0]           resp_data,
    output logic [NUM_PORTS-1:0]        resp_valid,
    output logic                        resp_last,
    output logic [3:0]                  arid,
    output logic [ADDR_W-1:0]           araddr,
    output logic [3:0]                  arlen,
    output logic [2:0]                  arsize,
    output logic [1:0]                  arburst,
    output logic [1:0]                  arlock,
    output logic [3:0]                  arcache,
    output logic [2:0]                  arprot,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [3:0]                  rid,
    input  logic [DATA_W-1:0]           rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rlast,
    input  logic                        rvalid,
    output logic                        rready
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic               gnt_found;
    logic               accept;
    logic [ADDR_W-1:0]  addr_q;
    logic [3:0]         len_q;
    logic [2:0]         size_q;
    logic               drain_q;
    logic [3:0]         beat_cnt;
    logic               unused_ok;

    // rid/rresp carry no information for a single outstanding burst
    assign unused_ok = ^{rid, rresp, beat_cnt};

`ifdef AXI_RD_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    always_comb begin
        int idx;
        idx       = 0;
        grant_d   = '0;
        gnt_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_PORTS;
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                grant_d   = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= IDX_W'((int'(grant_d) + 1) % NUM_PORTS);
        end
    end
`else
    always_comb begin
        grant_d   = '0;
        gnt_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!gnt_found && req_valid[i]) begin
                gnt_found = 1'b1;
                grant_d   = IDX_W'(i);
            end
        end
    end
`endif

    assign accept = (state_q == IDLE) && gnt_found && !flush && !areset;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_d] = 1'b1;
        end
    end

    assign araddr    = addr_q;
    assign arlen     = len_q;
    assign arsize    = size_q;
    assign arid      = 4'(grant_q);
    assign arburst   = 2'b01;
    assign arlock    = 2'b00;
    assign arcache   = 4'b0000;
    assign arprot    = 3'b000;
    assign resp_data = rdata;

    always_comb begin
        state_d    = state_q;
        arvalid    = 1'b0;
        rready     = 1'b0;
        resp_valid = '0;
        resp_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = (drain_q || flush) ? DRAIN : DATA;
                end
            end
            DATA: begin
                rready = 1'b1;
                if (rvalid && !flush && !areset) begin
                    resp_valid[grant_q] = 1'b1;
                    resp_last           = rlast;
                end
                if (rvalid && rlast) begin
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                rready = 1'b1;
                if (rvalid && rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            drain_q  <= 1'b0;
            beat_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q  <= grant_d;
                addr_q   <= req_addr[int'(grant_d)*ADDR_W +: ADDR_W];
                len_q    <= req_len[int'(grant_d)*4 +: 4];
                size_q   <= req_size[int'(grant_d)*3 +: 3];
                drain_q  <= 1'b0;
                beat_cnt <= '0;
            end
            if (state_q == ADDR && flush) begin
                drain_q <= 1'b1;
            end
            // saturates at len; completion is still decided by rlast
            if (state_q == DATA && rvalid && beat_cnt != len_q) begin
                beat_cnt <= beat_cnt + 4'd1;
            end
        end
    end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of read requesters (1..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width (32 or 64).
REQ-004 SHALL have port aclk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port areset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  in  1  abort current transaction, discard its data.
REQ-007 SHALL have port req_valid  in  NUM_PORTS  per-port read request valid.
REQ-008 SHALL have port req_ready  out  NUM_PORTS  per-port request accepted.
REQ-009 SHALL have port req_addr  in  NUM_PORTS*ADDR_W  per-port address, port i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port req_len  in  NUM_PORTS*4  per-port burst length minus 1 (AXI3 arlen).
REQ-011 SHALL have port req_size  in  NUM_PORTS*3  per-port beat size.
REQ-012 SHALL have port resp_data  out  DATA_W  shared read data.
REQ-013 SHALL have port resp_valid  out  NUM_PORTS  one-hot beat valid to the owning port.
REQ-014 SHALL have port resp_last  out  1  marks the final beat.
REQ-015 SHALL have AXI3 read-address ports arid(4), araddr(ADDR_W), arlen(4), arsize(3), arburst(2), arlock(2), arcache(4), arprot(3), arvalid out; arready in.
REQ-016 SHALL have AXI3 read-data ports rid(4), rdata(DATA_W), rresp(2), rlast, rvalid in; rready out.

Function
REQ-017 SHALL use FSM states IDLE, ADDR, DATA, DRAIN; one outstanding transaction.
REQ-018 IDLE: any req_valid set -> grant one port; pulse req_ready[grant] for 1 cycle; latch addr/len/size/grant; next ADDR.
REQ-019 ADDR: arvalid=1; araddr/arlen/arsize from latch; arid=grant index; arburst=2'b01; arlock/arcache/arprot=0; on arready -> DATA.
REQ-020 arvalid and the ar* payload SHALL stay stable until arready (no withdrawal, including on flush).
REQ-021 DATA: rready=1; each rvalid beat -> resp_data=rdata, resp_valid[grant]=1 in the same cycle (combinational, zero latency).
REQ-022 DATA: beat with rlast=1 -> resp_last=1 and next IDLE; rresp and rid are ignored.
REQ-023 A beat counter SHALL count accepted beats; if count reaches latched len with rlast=0, SHALL still wait for rlast.
REQ-024 flush in IDLE: no effect; request acceptance in the same cycle is suppressed.
REQ-025 flush in ADDR: set drain flag; after arready -> DRAIN instead of DATA.
REQ-026 flush in DATA: next DRAIN; the flush-cycle beat is not forwarded.
REQ-027 DRAIN: rready=1, resp_valid=0; on rvalid&rlast -> IDLE.
REQ-028 flush SHALL NOT affect req_ready of the grant already issued.
REQ-029 Earliest re-grant after rlast SHALL be the cycle after rlast (IDLE cycle).

Reset
REQ-030 areset SHALL force IDLE, req_ready=0, resp_valid=0, resp_last=0, arvalid=0, rready=0, beat counter=0, drain flag=0, round-robin pointer=0.
REQ-031 areset mid-transaction SHALL abandon it immediately; no beats are forwarded after reset.

Configuration
REQ-032 Macro AXI_RD_ARB_RR_EN defined: round-robin; search starts at (last grant+1) mod NUM_PORTS; pointer updates on each grant.
REQ-033 AXI_RD_ARB_RR_EN undefined: fixed priority, lowest index wins; no pointer register.

Verification
REQ-034 Port0 req addr 0x1fc00000 len 0, arready after 2 cycles, rdata 0xdeadbeef rlast -> arid=0, resp_valid=2'b01, resp_last=1, back to IDLE.
REQ-035 Port1 len 3 at 0x80001000 -> arlen=3, arid=1, 4 beats on resp_valid[1], resp_last only on 4th.
REQ-036 Both ports valid continuously, RR_EN defined -> grants alternate 0,1,0,1; undefined -> port0 always.
REQ-037 flush during ADDR with arready delayed 3 cycles -> arvalid held 3 cycles, then 2 beats drained, resp_valid=0 throughout.
REQ-038 areset asserted on beat 2 of 4 -> next cycle rready=0, arvalid=0, resp_valid=0, state IDLE.
